// File: rtl/stream_flag_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_flag_checker_if : character stream and verdict bundle | Rev 1.0
// ---------------------------------------------------------------------------
interface stream_flag_checker_if #(
  parameter int NUM_CHUNKS = 8
);
  localparam int FW = $clog2(NUM_CHUNKS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          clear;
  logic          result_valid;
  logic          is_correct;
  logic [FW-1:0] fail_chunk;

  modport master (
    output in_valid, in_data, in_last, clear,
    input  in_ready, result_valid, is_correct, fail_chunk
  );

  modport slave (
    input  in_valid, in_data, in_last, clear,
    output in_ready, result_valid, is_correct, fail_chunk
  );
endinterface
`default_nettype wire

// File: rtl/stream_flag_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_flag_checker : byte-serial chunked flag checker | Rev 1.0
// ---------------------------------------------------------------------------
module stream_flag_checker #(
  parameter int NUM_CHUNKS  = 8,
  parameter int CHUNK_BYTES = 8,
  parameter logic [2*NUM_CHUNKS-1:0]               OPS      = '0,
  parameter logic [NUM_CHUNKS*CHUNK_BYTES*8-1:0]   KEYS     = '0,
  parameter logic [NUM_CHUNKS*CHUNK_BYTES*8-1:0]   EXPECTED = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_flag_checker_if.slave  bus
);
  localparam int FW  = $clog2(NUM_CHUNKS + 1);
  localparam int CW  = 8 * CHUNK_BYTES;
  localparam int BW  = (CHUNK_BYTES > 1) ? $clog2(CHUNK_BYTES) : 1;
  localparam int TAB = 1 << FW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [BW-1:0] byte_idx;
  logic [FW-1:0] chunk_idx;
  logic [CW-1:0] chunk_reg, chunk_full;
  logic          cmp_valid;
  logic [FW-1:0] cmp_idx;
  logic [1:0]    cmp_op;
  logic [CW-1:0] cmp_data, cmp_xf;
  logic          failed, check_wait;
  logic [FW-1:0] fail_chunk;
  logic          ready, accept, chunk_done, last_byte, final_byte;
  logic          mismatch, bad_char, len_err;

  // Tables padded to the full index range so chunk/compare indices select directly
  logic [CW-1:0] key_tab [TAB];
  logic [CW-1:0] exp_tab [TAB];
  logic [1:0]    op_tab  [TAB];

  for (genvar i = 0; i < TAB; i++) begin : g_tab
    if (i < NUM_CHUNKS) begin : g_used
      assign key_tab[i] = KEYS[i*CW +: CW];
      assign exp_tab[i] = EXPECTED[i*CW +: CW];
      assign op_tab[i]  = OPS[2*i +: 2];
    end else begin : g_pad
      assign key_tab[i] = '0;
      assign exp_tab[i] = '0;
      assign op_tab[i]  = 2'd0;
    end
  end

  function automatic logic is_alpha(input logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") ||
           (c >= "0" && c <= "9") || c == "_" || c == "{" || c == "}";
  endfunction

  assign ready      = !rst && (state == IDLE || state == RECV);
  assign accept     = bus.in_valid && ready;
  assign chunk_done = accept && (byte_idx == BW'(CHUNK_BYTES - 1));
  assign last_byte  = (chunk_idx == FW'(NUM_CHUNKS - 1)) && (byte_idx == BW'(CHUNK_BYTES - 1));
  assign final_byte = accept && (bus.in_last || last_byte);
  assign bad_char   = accept && !is_alpha(bus.in_data);
  assign len_err    = accept && (bus.in_last != last_byte);
  assign mismatch   = cmp_valid && (cmp_xf != exp_tab[cmp_idx]);

  // Chunk value including the byte being accepted this cycle
  always_comb begin
    chunk_full = chunk_reg;
    for (int b = 0; b < CHUNK_BYTES; b++)
      if (byte_idx == BW'(b)) chunk_full[8*b +: 8] = bus.in_data;
  end

  always_comb begin
    cmp_xf = cmp_data;
    case (cmp_op)
      2'd1:    cmp_xf = cmp_data ^ key_tab[cmp_idx];
      2'd2:    cmp_xf = ~cmp_data;
      2'd3:    cmp_xf = cmp_data + key_tab[cmp_idx];
      default: cmp_xf = cmp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_reg  <= '0;
      byte_idx   <= '0;
      chunk_idx  <= '0;
      cmp_valid  <= 1'b0;
      cmp_idx    <= '0;
      cmp_op     <= 2'd0;
      cmp_data   <= '0;
      failed     <= 1'b0;
      fail_chunk <= '0;
      check_wait <= 1'b0;
    end else begin
      cmp_valid  <= chunk_done;
      check_wait <= (state == CHECK);
      if (accept) chunk_reg <= chunk_full;
      if (chunk_done) begin
        cmp_idx  <= chunk_idx;
        cmp_op   <= op_tab[chunk_idx];
        cmp_data <= chunk_full;
      end
      if (state == DONE && bus.clear) begin
        byte_idx   <= '0;
        chunk_idx  <= '0;
        failed     <= 1'b0;
        fail_chunk <= '0;
      end else begin
        if (accept) byte_idx <= chunk_done ? '0 : byte_idx + BW'(1);
        if (chunk_done) chunk_idx <= chunk_idx + FW'(1);
        // Same-edge ties go to the lowest index: older chunk, then current chunk, then length
        if (!failed && (mismatch || bad_char || len_err)) begin
          failed <= 1'b1;
          if (mismatch)      fail_chunk <= cmp_idx;
          else if (bad_char) fail_chunk <= chunk_idx;
          else               fail_chunk <= FW'(NUM_CHUNKS);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.result_valid = 1'b0;
    bus.is_correct   = 1'b0;
    case (state)
      IDLE, RECV: if (accept) state_next = final_byte ? CHECK : RECV;
      CHECK:      if (check_wait) state_next = DONE;
      DONE: begin
        bus.result_valid = 1'b1;
        bus.is_correct   = !failed;
        if (bus.clear) state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
  end

  assign bus.in_ready   = ready;
  assign bus.fail_chunk = fail_chunk;
endmodule
`default_nettype wire

// File: tb/tb_stream_flag_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stream_flag_checker : three configurations against a verdict model | Rev 1.0
// ---------------------------------------------------------------------------
module tb_stream_flag_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_last, clear;
  logic [7:0] in_data;
  int         sel = 0;
  int         n_cmp = 0, n_fail = 0;
  bit         chk_en = 1'b0;
  bit         exp_ready = 1'b0, exp_rv = 1'b0, exp_ok = 1'b0;
  logic [1:0] exp_fc = 2'd0;

  int          cfg_num [3] = '{2, 2, 3};
  int          cfg_cb  [3] = '{8, 8, 1};
  int          cfg_op  [3][3];
  logic [63:0] cfg_key [3][3];
  logic [63:0] cfg_exp [3][3];
  logic [7:0]  flag    [3][16];
  logic [7:0]  stim    [16];

  stream_flag_checker_if #(.NUM_CHUNKS(2)) ifa ();
  stream_flag_checker_if #(.NUM_CHUNKS(2)) ifb ();
  stream_flag_checker_if #(.NUM_CHUNKS(3)) ifc ();

  assign ifa.in_valid = in_valid && sel == 0;
  assign ifb.in_valid = in_valid && sel == 1;
  assign ifc.in_valid = in_valid && sel == 2;
  assign ifa.clear = clear && sel == 0;
  assign ifb.clear = clear && sel == 1;
  assign ifc.clear = clear && sel == 2;
  assign ifa.in_data = in_data;
  assign ifb.in_data = in_data;
  assign ifc.in_data = in_data;
  assign ifa.in_last = in_last;
  assign ifb.in_last = in_last;
  assign ifc.in_last = in_last;

  stream_flag_checker #(
    .NUM_CHUNKS(2), .CHUNK_BYTES(8), .OPS(4'b1000), .KEYS(128'h0),
    .EXPECTED({64'h8da08ccea09b9890, 64'h35617b49414b4553})
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  stream_flag_checker #(
    .NUM_CHUNKS(2), .CHUNK_BYTES(8), .OPS(4'b1101),
    .KEYS({64'd1, 64'hb5d34b5f62469ec7}),
    .EXPECTED({64'h725f73315f646770, 64'hd9bd393a1636e898})
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  stream_flag_checker #(
    .NUM_CHUNKS(3), .CHUNK_BYTES(1), .OPS(6'b0), .KEYS(24'h0),
    .EXPECTED(24'h636261)
  ) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic       ready_m, rv_m, ok_m;
  logic [1:0] fc_m;
  always_comb begin
    ready_m = ifa.in_ready; rv_m = ifa.result_valid; ok_m = ifa.is_correct; fc_m = ifa.fail_chunk;
    if (sel == 1) begin
      ready_m = ifb.in_ready; rv_m = ifb.result_valid; ok_m = ifb.is_correct; fc_m = ifb.fail_chunk;
    end else if (sel == 2) begin
      ready_m = ifc.in_ready; rv_m = ifc.result_valid; ok_m = ifc.is_correct; fc_m = ifc.fail_chunk;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s (cfg %0d): got %0h, expected %0h at %0t", name, sel, act, want, $time);
    end
  endtask

  function automatic bit alpha(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a) ||
           (c >= 8'h30 && c <= 8'h39) || c == 8'h5f || c == 8'h7b || c == 8'h7d;
  endfunction

  // Verdict = earliest failure event by stream position (chunk compares land one
  // position after their last byte); equal positions resolve to the lower index.
  task automatic model_verdict(input int s, input int last_idx, input bit has_last,
                               output bit ok, output logic [1:0] fc);
    int ev_t[$], ev_i[$];
    int cb, num, bt, bi;
    logic [63:0] mask, val, xf;
    cb = cfg_cb[s];
    num = cfg_num[s];
    mask = (cb == 8) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << (8*cb)) - 64'd1);
    for (int i = 0; i <= last_idx; i++)
      if (!alpha(stim[i])) begin ev_t.push_back(i); ev_i.push_back(i / cb); end
    for (int k = 0; k < num; k++) begin
      if ((k + 1) * cb - 1 <= last_idx) begin
        val = 64'd0;
        for (int j = 0; j < cb; j++) val = val | (64'(stim[k*cb + j]) << (8*j));
        case (cfg_op[s][k])
          0:       xf = val;
          1:       xf = val ^ cfg_key[s][k];
          2:       xf = ~val;
          default: xf = val + cfg_key[s][k];
        endcase
        xf = xf & mask;
        if (xf != cfg_exp[s][k]) begin ev_t.push_back((k + 1) * cb); ev_i.push_back(k); end
      end
    end
    if (!(has_last && last_idx == num * cb - 1)) begin ev_t.push_back(last_idx); ev_i.push_back(num); end
    bt = 1 << 30;
    bi = 0;
    foreach (ev_t[e])
      if (ev_t[e] < bt || (ev_t[e] == bt && ev_i[e] < bi)) begin bt = ev_t[e]; bi = ev_i[e]; end
    ok = (ev_t.size() == 0);
    fc = ok ? 2'd0 : 2'(bi);
  endtask

  task automatic load(input int s);
    for (int i = 0; i < 16; i++) stim[i] = flag[s][i];
  endtask

  // Called at posedge+1 with the selected DUT in IDLE; returns the same way.
  task automatic run_stream(input int s, input int last_pos, input bit hold, input bit gaps,
                            input bit use_lit, input bit lit_ok, input logic [1:0] lit_fc);
    int  total, last_idx;
    bit  has_last, m_ok;
    logic [1:0] m_fc;
    total    = cfg_num[s] * cfg_cb[s];
    has_last = (last_pos >= 0);
    last_idx = has_last ? last_pos : total - 1;
    model_verdict(s, last_idx, has_last, m_ok, m_fc);
    if (use_lit) begin
      check("model_is_correct", 64'(m_ok), 64'(lit_ok));
      check("model_fail_chunk", 64'(m_fc), 64'(lit_fc));
    end
    sel = s;
    for (int i = 0; i <= last_idx; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          clear = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = has_last && i == last_idx;
      clear    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    clear     = 1'b0;
    in_valid  = hold;
    in_data   = 8'h41;
    in_last   = 1'b0;
    exp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_rv = 1'b1;
    exp_ok = m_ok;
    exp_fc = m_fc;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear     = 1'b0;
    exp_rv    = 1'b0;
    exp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(ready_m), 64'(exp_ready));
      check("result_valid", 64'(rv_m), 64'(exp_rv));
      if (exp_rv) begin
        check("is_correct", 64'(ok_m), 64'(exp_ok));
        check("fail_chunk", 64'(fc_m), 64'(exp_fc));
      end
    end
  end

  initial begin
    string fa, fb, fcs, alph;
    int s, total, p, last_pos;
    logic [63:0] v;

    fa = "SEKAI{a5ogd_1s_r";
    fb = "_vpternlogd_1s_r";
    fcs = "abc";
    alph = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789_{}";
    for (int i = 0; i < 16; i++) begin
      flag[0][i] = fa[i];
      flag[1][i] = fb[i];
      flag[2][i] = (i < 3) ? fcs[i] : 8'h00;
    end
    for (int a = 0; a < 3; a++)
      for (int k = 0; k < 3; k++) begin
        cfg_op[a][k] = 0; cfg_key[a][k] = 64'd0; cfg_exp[a][k] = 64'd0;
      end
    cfg_op[0][1]  = 2;
    cfg_exp[0][0] = 64'h35617b49414b4553;
    cfg_exp[0][1] = 64'h8da08ccea09b9890;
    cfg_op[1][0]  = 1;
    cfg_op[1][1]  = 3;
    cfg_key[1][0] = 64'hb5d34b5f62469ec7;
    cfg_key[1][1] = 64'd1;
    cfg_exp[1][0] = 64'hd9bd393a1636e898;
    v = 64'd0;
    for (int j = 0; j < 8; j++) v = v | (64'(flag[1][8 + j]) << (8*j));
    cfg_exp[1][1] = v + 64'd1;
    cfg_exp[2][0] = 64'h61;
    cfg_exp[2][1] = 64'h62;
    cfg_exp[2][2] = 64'h63;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; clear = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready_a", 64'(ifa.in_ready), 64'd0);
    check("rst_in_ready_b", 64'(ifb.in_ready), 64'd0);
    check("rst_in_ready_c", 64'(ifc.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready_a", 64'(ifa.in_ready), 64'd1);
    check("post_rst_rv_a", 64'(ifa.result_valid), 64'd0);
    check("post_rst_ok_a", 64'(ifa.is_correct), 64'd0);
    check("post_rst_fc_a", 64'(ifa.fail_chunk), 64'd0);
    check("post_rst_ready_c", 64'(ifc.in_ready), 64'd1);
    check("post_rst_rv_c", 64'(ifc.result_valid), 64'd0);
    check("post_rst_fc_c", 64'(ifc.fail_chunk), 64'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;

    load(0); run_stream(0, 15, 0, 0, 1, 1, 2'd0);
    load(0); stim[3] = 8'h21; run_stream(0, 15, 0, 0, 1, 0, 2'd0);
    load(0); stim[10] = 8'h78; run_stream(0, 15, 0, 0, 1, 0, 2'd1);
    load(0); run_stream(0, 12, 0, 0, 1, 0, 2'd2);
    load(0); run_stream(0, -1, 1, 0, 1, 0, 2'd2);
    load(1); run_stream(1, 15, 0, 0, 1, 1, 2'd0);
    load(1); stim[2] = stim[2] ^ 8'h01; run_stream(1, 15, 0, 0, 1, 0, 2'd0);
    load(1); stim[12] = stim[12] ^ 8'h01; run_stream(1, 15, 0, 0, 1, 0, 2'd1);

    // Reset lands on the edge that would accept byte 6
    load(0); sel = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = stim[i]; in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_data = stim[6]; rst = 1'b1; exp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; exp_ready = 1'b1;
    @(negedge clk);
    check("midrst_rv", 64'(ifa.result_valid), 64'd0);
    check("midrst_ok", 64'(ifa.is_correct), 64'd0);
    check("midrst_fc", 64'(ifa.fail_chunk), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    load(0); run_stream(0, 15, 0, 0, 1, 1, 2'd0);

    load(2); run_stream(2, 2, 0, 0, 1, 1, 2'd0);
    load(2); stim[2] = 8'h64; run_stream(2, 2, 0, 0, 1, 0, 2'd2);

    for (int it = 0; it < 60; it++) begin
      s = $urandom_range(0, 2);
      load(s);
      total = cfg_num[s] * cfg_cb[s];
      p = $urandom_range(0, total - 1);
      case ($urandom_range(0, 3))
        1: stim[p] = alph[$urandom_range(0, alph.len() - 1)];
        2: stim[p] = 8'($urandom_range(0, 255));
        3: stim[p] = stim[p] ^ (8'd1 << $urandom_range(0, 7));
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0, 1:    last_pos = $urandom_range(0, total - 1);
        2:       last_pos = -1;
        default: last_pos = total - 1;
      endcase
      run_stream(s, last_pos, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 2'd0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stream_flag_checker.md
# stream_flag_checker

Byte-serial, parametrised flag checker. It accepts a candidate flag one character per handshake, checks every character against the flag alphabet, and packs the characters into fixed-width chunks. Each completed chunk goes through a per-chunk transform (equal, XOR-key, invert, add-key) and is compared against a parameter-supplied constant. It sits between the character input stream (UART/host FIFO) and the result/status logic, and replaces the fixed 64-character combinational checker.

## Interface
- NUM_CHUNKS, 8: number of chunks in the flag; flag length = NUM_CHUNKS*CHUNK_BYTES.
- CHUNK_BYTES, 8: bytes per chunk (1..8).
- OPS, 0: packed 2 bits per chunk, chunk k at [2k+1:2k]; 0=EQ, 1=XOR key, 2=NOT, 3=ADD key mod 2^(8*CHUNK_BYTES).
- KEYS, 0: packed CHUNK_BYTES*8 bits per chunk; chunk k at slice k.
- EXPECTED, 0: packed CHUNK_BYTES*8 bits per chunk; the transformed chunk must equal this value.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  character present.
- in_ready  out  1  block can accept a character.
- in_data  in  8  character.
- in_last  in  1  marks the final character of the candidate.
- clear  in  1  returns the block from DONE to IDLE.
- result_valid  out  1  verdict is available.
- is_correct  out  1  verdict; meaningful only while result_valid=1.
- fail_chunk  out  $clog2(NUM_CHUNKS+1)  index of the first failing chunk; NUM_CHUNKS when the failure is a length error; 0 when correct.

## Operation
- A byte is accepted when in_valid && in_ready.
- Byte packing: the first byte of a chunk goes to bits [7:0] of the chunk register, the next byte to [15:8], and so on. The ASCII sequence "SEKAI{a5" therefore forms chunk value "5a{IAKES".
- Valid alphabet: a-z, A-Z, 0-9, '_', '{', '}'. An invalid byte sets the sticky error bit. It also records the current chunk index as the failure, if no failure has been recorded yet.
- On the accepted byte that completes a chunk:
  - the chunk register, its index and the op are registered into the compare stage;
  - in the next cycle the transform is applied and compared against EXPECTED;
  - a mismatch records the index if no failure has been recorded yet.
- Length check: the length is wrong if in_last arrives on any byte other than byte NUM_CHUNKS*CHUNK_BYTES-1, or if that byte arrives without in_last. Either case forces a failure with index NUM_CHUNKS, unless an earlier chunk failure has already been recorded.
- The block does not accept bytes past the declared length. With a missing in_last, it stops at the final byte and goes to CHECK.
- FSM:
  - IDLE: in_ready=1. The first accepted byte goes to RECV (or straight to CHECK if it carries in_last or completes the flag).
  - RECV: in_ready=1. Accepting in_last or the final byte goes to CHECK.
  - CHECK: in_ready=0. Waits one cycle so the compare stage drains, then goes to DONE.
  - DONE: in_ready=0, result_valid=1, is_correct = no failure recorded. clear goes to IDLE and resets the byte and chunk counters, the error bit and fail_chunk.
- clear outside DONE is ignored.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 afterwards (IDLE), result_valid=0, is_correct=0, fail_chunk=0. Counters, error bit and compare stage are all zero.
- A reset mid-stream abandons the candidate with no verdict.
- Latency: the last byte is accepted at edge T. The FSM is in CHECK in cycle T+1, and result_valid rises after edge T+2.
- An invalid byte is flagged on the edge at which it is accepted.
- A chunk compare resolves one edge after the chunk's final byte.
- in_valid may stay high continuously, giving one byte per cycle. There is no backpressure other than CHECK and DONE.
- When clear is sampled in DONE, result_valid falls on the next edge and in_ready=1 in the following cycle.

## Test plan
- NUM_CHUNKS=2, CHUNK_BYTES=8:
  - Chunk 0 is EQ with EXPECTED "5a{IAKES".
  - Chunk 1 is NOT with EXPECTED 64'h8da08ccea09b9890.
  - Stream "SEKAI{a5ogd_1s_r" back-to-back with in_last on byte 15 -> result_valid two cycles after byte 15, is_correct=1, fail_chunk=0.
- Same config, byte 3 = '!' -> is_correct=0, fail_chunk=0. Also byte 10 wrong but valid -> fail_chunk=1.
- in_last on byte 12 -> is_correct=0, fail_chunk=2. Also 16 bytes with no in_last -> in_ready drops after byte 15, is_correct=0, fail_chunk=2.
- Chunk 0 XOR key 64'hb5d34b5f62469ec7 with EXPECTED 64'hd9bd393a1636e898, chunk 1 ADD key 1 with EXPECTED = chunk1+1 -> correct verdict. Flipping one bit in either chunk -> that chunk index is reported.
- Assert rst while byte 6 is being accepted -> no result_valid, outputs at reset values. A following correct stream -> is_correct=1. Pulse clear in DONE -> back to IDLE and a second candidate is judged independently.
- CHUNK_BYTES=1, NUM_CHUNKS=3, EXPECTED "a","b","c" with EQ -> "abc" gives correct; "abd" gives fail_chunk=2.
